// File: rtl/powlib_piso.sv
// Parallel-in, serial-out width converter: one N*W-bit word in, N W-bit beats out,
// with back-to-back words accepted on the last beat so the output never bubbles.
module powlib_piso #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int MSBF = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   idata,
  input  logic             ivld,
  output logic             irdy,
  output logic [W-1:0]     odata,
  output logic             ovld,
  input  logic             ordy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [N*W-1:0]  sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy;
  logic            last;
  logic            out_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q == SHIFT);
  assign last    = (cnt_q == CW'(N - 1));
  assign out_acc = busy & ordy;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ivld) begin
          sr_d    = idata;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_acc) begin
          if (!last) begin
            // Move the next beat toward whichever end odata is taken from.
            sr_d  = (MSBF != 0) ? (sr_q << W) : (sr_q >> W);
            cnt_d = cnt_q + 1'b1;
          end else if (ivld) begin
            sr_d  = idata;
            cnt_d = '0;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    irdy  = ~busy | (busy & ordy & last);
    ovld  = busy;
    odata = (MSBF != 0) ? sr_q[N*W-1 -: W] : sr_q[W-1:0];
  end

endmodule
